// File: rtl/imem_port_arb_if.sv
// Bus bundle for the instruction-memory arbiter: fetch port, loader/debug port
// and the single-byte memory array port. Bit 0 is the most significant bit.
interface imem_port_arb_if;
  logic        f_req;
  logic [0:31] f_addr;
  logic        f_gnt;
  logic        f_valid;
  logic [0:31] f_data;
  logic        f_err;

  logic        l_req;
  logic        l_we;
  logic [0:31] l_addr;
  logic [0:31] l_wdata;
  logic        l_gnt;
  logic        l_valid;
  logic [0:31] l_rdata;
  logic        l_err;

  logic [0:31] m_addr;
  logic        m_we;
  logic [0:7]  m_wdata;
  logic [0:7]  m_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    output f_gnt, f_valid, f_data, f_err,
    output l_gnt, l_valid, l_rdata, l_err,
    output m_addr, m_we, m_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  f_gnt, f_valid, f_data, f_err,
    input  l_gnt, l_valid, l_rdata, l_err,
    input  m_addr, m_we, m_wdata
  );
endinterface

// File: rtl/imem_port_arb.sv
// Round-robin arbiter between fetch and loader ports for a byte-wide instruction
// memory; moves big-endian 32-bit words as four byte cycles with range/alignment faults.
module imem_port_arb #(
  parameter int unsigned SIZE   = 4096,
  parameter logic [31:0] OFFSET = 32'h0
) (
  input logic            clk,
  input logic            rst_n,
  imem_port_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic        OWN_F   = 1'b0;
  localparam logic        OWN_L   = 1'b1;
  localparam logic [31:0] LAST_OK = 32'(SIZE - 4);

  function automatic logic [0:7] get_byte(input logic [0:31] w, input logic [1:0] k);
    case (k)
      2'd0:    get_byte = w[0:7];
      2'd1:    get_byte = w[8:15];
      2'd2:    get_byte = w[16:23];
      default: get_byte = w[24:31];
    endcase
  endfunction

  function automatic logic [0:31] put_byte(input logic [0:31] w, input logic [1:0] k,
                                           input logic [0:7] b);
    put_byte = w;
    case (k)
      2'd0:    put_byte[0:7]   = b;
      2'd1:    put_byte[8:15]  = b;
      2'd2:    put_byte[16:23] = b;
      default: put_byte[24:31] = b;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  k_q;
  logic        last_q, owner_q, we_q;
  logic [31:0] phys_q;
  logic [0:31] wdata_q, buf_q, rd_word;
  logic [0:31] f_data_q, l_rdata_q;
  logic        f_err_q, l_err_q;
  logic        f_win, l_win, gnt_any, sel_fault;
  logic [0:31] sel_addr;
  logic [31:0] sel_phys;

  // Grants are suppressed while reset is asserted so no request is lost to it.
  assign f_win   = rst_n && (state_q == IDLE) && bus.f_req && (!bus.l_req || last_q == OWN_L);
  assign l_win   = rst_n && (state_q == IDLE) && bus.l_req && (!bus.f_req || last_q == OWN_F);
  assign gnt_any = f_win | l_win;

  // Wrap-around of the subtraction makes addresses below OFFSET fail the range test.
  assign sel_addr  = l_win ? bus.l_addr : bus.f_addr;
  assign sel_phys  = sel_addr - OFFSET;
  assign sel_fault = (sel_addr[30:31] != 2'b00) || (sel_phys > LAST_OK);
  assign rd_word   = put_byte(buf_q, k_q, bus.m_rdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = sel_fault ? RESP : XFER;
      XFER:    if (k_q == 2'd3) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= 2'd0;
      last_q    <= OWN_L;
      owner_q   <= OWN_F;
      we_q      <= 1'b0;
      f_data_q  <= '0;
      f_err_q   <= 1'b0;
      l_rdata_q <= '0;
      l_err_q   <= 1'b0;
    end else if (gnt_any) begin
      k_q     <= 2'd0;
      last_q  <= l_win;
      owner_q <= l_win;
      we_q    <= l_win & bus.l_we;
      if (sel_fault) begin
        if (l_win) begin
          l_rdata_q <= '0;
          l_err_q   <= 1'b1;
        end else begin
          f_data_q <= '0;
          f_err_q  <= 1'b1;
        end
      end
    end else if (state_q == XFER) begin
      k_q <= k_q + 2'd1;
      if (k_q == 2'd3) begin
        if (owner_q == OWN_L) begin
          l_rdata_q <= we_q ? '0 : rd_word;
          l_err_q   <= 1'b0;
        end else begin
          f_data_q <= rd_word;
          f_err_q  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_any) begin
      phys_q  <= sel_phys;
      wdata_q <= bus.l_wdata;
      buf_q   <= '0;
    end else if (state_q == XFER) begin
      buf_q <= rd_word;
    end
  end

  always_comb begin
    bus.f_gnt   = f_win;
    bus.l_gnt   = l_win;
    bus.f_valid = (state_q == RESP) && (owner_q == OWN_F);
    bus.l_valid = (state_q == RESP) && (owner_q == OWN_L);
    bus.f_data  = f_data_q;
    bus.f_err   = f_err_q;
    bus.l_rdata = l_rdata_q;
    bus.l_err   = l_err_q;
    bus.m_addr  = '0;
    bus.m_we    = 1'b0;
    bus.m_wdata = '0;
    if (state_q == XFER) begin
      bus.m_addr = phys_q + 32'(k_q);
      bus.m_we   = we_q;
      if (we_q) bus.m_wdata = get_byte(wdata_q, k_q);
    end
  end
endmodule

// File: tb/tb_imem_port_arb.sv
// Directed bench for imem_port_arb: one instance at OFFSET 0 for data paths and
// arbitration, one at OFFSET 0x1000 for range/alignment faults.
module tb_imem_port_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  mem0 [0:4095];
  logic [7:0]  mem1 [0:4095];

  imem_port_arb_if bus0 ();
  imem_port_arb_if bus1 ();

  imem_port_arb #(.SIZE(4096), .OFFSET(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  imem_port_arb #(.SIZE(4096), .OFFSET(32'h0000_1000)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  assign bus0.m_rdata = mem0[bus0.m_addr[20:31]];
  assign bus1.m_rdata = mem1[bus1.m_addr[20:31]];

  always @(posedge clk) begin
    if (pl_we) mem0[pl_addr] <= pl_data;
    else if (bus0.m_we) mem0[bus0.m_addr[20:31]] <= bus0.m_wdata;
    if (bus1.m_we) mem1[bus1.m_addr[20:31]] <= bus1.m_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Legal access on dut0, entered at a negedge with the FSM idle; returns at the
  // negedge of T+6 with the FSM idle again.
  task automatic run0(input logic lreq, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp);
    if (lreq) begin
      bus0.l_req = 1'b1; bus0.l_we = we; bus0.l_addr = addr; bus0.l_wdata = wdata;
    end else begin
      bus0.f_req = 1'b1; bus0.f_addr = addr;
    end
    #1;
    check("gnt", lreq ? bus0.l_gnt : bus0.f_gnt, 32'd1);
    check("other_gnt", lreq ? bus0.f_gnt : bus0.l_gnt, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (lreq) bus0.l_req = 1'b0; else bus0.f_req = 1'b0;
      end
      #1;
      check("m_addr", bus0.m_addr, addr + 32'(k));
      check("m_we", 32'(bus0.m_we), 32'(we));
      check("m_wdata", 32'(bus0.m_wdata), we ? ((wdata >> (24 - 8 * k)) & 32'hFF) : 32'd0);
    end
    @(negedge clk); #1;
    check("valid", lreq ? bus0.l_valid : bus0.f_valid, 32'd1);
    check("other_valid", lreq ? bus0.f_valid : bus0.l_valid, 32'd0);
    check("data", lreq ? bus0.l_rdata : bus0.f_data, exp);
    check("err", lreq ? bus0.l_err : bus0.f_err, 32'd0);
    @(negedge clk);
  endtask

  // Faulting access on dut1: valid/err one cycle after the grant, no memory activity.
  task automatic fault1(input logic lreq, input logic we, input logic [31:0] addr);
    if (lreq) begin
      bus1.l_req = 1'b1; bus1.l_we = we; bus1.l_addr = addr; bus1.l_wdata = 32'hFFFF_FFFF;
    end else begin
      bus1.f_req = 1'b1; bus1.f_addr = addr;
    end
    #1;
    check("flt_gnt", lreq ? bus1.l_gnt : bus1.f_gnt, 32'd1);
    @(negedge clk);
    bus1.f_req = 1'b0; bus1.l_req = 1'b0;
    #1;
    check("flt_valid", lreq ? bus1.l_valid : bus1.f_valid, 32'd1);
    check("flt_err", lreq ? bus1.l_err : bus1.f_err, 32'd1);
    check("flt_data", lreq ? bus1.l_rdata : bus1.f_data, 32'd0);
    check("flt_m_we", 32'(bus1.m_we), 32'd0);
    check("flt_m_addr", bus1.m_addr, 32'd0);
    @(negedge clk); #1;
    check("flt_idle_valid", 32'(bus1.f_valid | bus1.l_valid), 32'd0);
    check("flt_idle_m_we", 32'(bus1.m_we), 32'd0);
  endtask

  initial begin
    bus0.f_req = 1'b0; bus0.f_addr = '0; bus0.l_req = 1'b0; bus0.l_we = 1'b0;
    bus0.l_addr = '0; bus0.l_wdata = '0;
    bus1.f_req = 1'b0; bus1.f_addr = '0; bus1.l_req = 1'b0; bus1.l_we = 1'b0;
    bus1.l_addr = '0; bus1.l_wdata = '0;

    // Preload during reset: bytes 0..3 = 11 22 33 44, bytes 16..19 = 55.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = (i < 4) ? 12'(i) : 12'(12 + i);
      pl_data = (i < 4) ? 8'(8'h11 * (i + 1)) : 8'h55;
    end
    @(negedge clk);
    pl_we = 1'b0;
    bus0.f_req = 1'b1; bus0.f_addr = 32'h0;
    #1;
    check("rst_f_gnt", 32'(bus0.f_gnt), 32'd0);
    check("rst_valid", 32'(bus0.f_valid | bus0.l_valid), 32'd0);
    check("rst_err", 32'(bus0.f_err | bus0.l_err), 32'd0);
    check("rst_f_data", bus0.f_data, 32'd0);
    check("rst_l_rdata", bus0.l_rdata, 32'd0);
    check("rst_m_we", 32'(bus0.m_we), 32'd0);
    check("rst_m_addr", bus0.m_addr, 32'd0);
    check("rst_m_wdata", 32'(bus0.m_wdata), 32'd0);

    // Reset release, then fetch of address 0.
    rst_n = 1'b1;
    run0(1'b0, 1'b0, 32'h0, 32'h0, 32'h1122_3344);
    #1;
    check("f_data_hold", bus0.f_data, 32'h1122_3344);
    check("f_valid_pulse", 32'(bus0.f_valid), 32'd0);

    // Loader write of DEADBEEF at address 8.
    run0(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0);

    // Both requesters held high: fetch (addr 8) and loader read (addr 0) alternate.
    bus0.f_req = 1'b1; bus0.f_addr = 32'h8;
    bus0.l_req = 1'b1; bus0.l_we = 1'b0; bus0.l_addr = 32'h0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("tie_f_gnt", 32'(bus0.f_gnt), 32'((c % 12) == 0));
      check("tie_l_gnt", 32'(bus0.l_gnt), 32'((c % 12) == 6));
      check("tie_f_valid", 32'(bus0.f_valid), 32'((c % 12) == 5));
      check("tie_l_valid", 32'(bus0.l_valid), 32'((c % 12) == 11));
      if ((c % 12) == 5)  check("tie_f_data", bus0.f_data, 32'hDEAD_BEEF);
      if ((c % 12) == 11) check("tie_l_rdata", bus0.l_rdata, 32'h1122_3344);
    end
    bus0.f_req = 1'b0; bus0.l_req = 1'b0;
    @(negedge clk);

    // Faults on the OFFSET = 0x1000 instance.
    fault1(1'b0, 1'b0, 32'h0000_0FFC);
    bus1.f_req = 1'b1; bus1.f_addr = 32'h0000_1FFC;
    #1;
    check("edge_gnt", 32'(bus1.f_gnt), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus1.f_req = 1'b0;
      #1;
      check("edge_m_addr", bus1.m_addr, 32'h0000_0FFC + 32'(k));
    end
    @(negedge clk); #1;
    check("edge_valid", 32'(bus1.f_valid), 32'd1);
    check("edge_err", 32'(bus1.f_err), 32'd0);
    @(negedge clk);
    fault1(1'b1, 1'b1, 32'h0000_2000);
    fault1(1'b0, 1'b0, 32'h0000_1002);

    // Reset during byte 2 of a loader write.
    @(negedge clk);
    bus0.l_req = 1'b1; bus0.l_we = 1'b1; bus0.l_addr = 32'h10; bus0.l_wdata = 32'hA1B2_C3D4;
    #1;
    check("mid_gnt", 32'(bus0.l_gnt), 32'd1);
    @(negedge clk);
    bus0.l_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("mid_m_addr_k2", bus0.m_addr, 32'h12);
    check("mid_m_we_k2", 32'(bus0.m_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_m_we", 32'(bus0.m_we), 32'd0);
    check("mid_m_addr", bus0.m_addr, 32'd0);
    check("mid_m_wdata", 32'(bus0.m_wdata), 32'd0);
    check("mid_l_rdata", bus0.l_rdata, 32'd0);
    check("mid_f_data", bus0.f_data, 32'd0);
    check("mid_err", 32'(bus0.f_err | bus0.l_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("mid_no_valid", 32'(bus0.f_valid | bus0.l_valid), 32'd0);
      @(negedge clk);
    end
    check("mem16", 32'(mem0[16]), 32'hA1);
    check("mem17", 32'(mem0[17]), 32'hB2);
    check("mem18", 32'(mem0[18]), 32'h55);
    check("mem19", 32'(mem0[19]), 32'h55);
    bus0.f_req = 1'b1; bus0.f_addr = 32'h0;
    bus0.l_req = 1'b1; bus0.l_we = 1'b0; bus0.l_addr = 32'h0;
    #1;
    check("post_rst_f_gnt", 32'(bus0.f_gnt), 32'd1);
    check("post_rst_l_gnt", 32'(bus0.l_gnt), 32'd0);

    // Fetch just won, so only a reset can put the pointer back to loader.
    @(negedge clk);
    bus0.f_req = 1'b0; bus0.l_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst2_m_addr", bus0.m_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus0.f_req = 1'b1; bus0.l_req = 1'b1;
    #1;
    check("rst2_f_gnt", 32'(bus0.f_gnt), 32'd1);
    check("rst2_l_gnt", 32'(bus0.l_gnt), 32'd0);
    @(negedge clk);
    bus0.f_req = 1'b0; bus0.l_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
